sort_mem_host: RTL and testbench

Host-side owner of the word memory that the in-place bubble sorter works on. It accepts a stream of 32-bit words from the host into an internal RAM, pulses `sort_go` with the correct length, and serves the sorter's memory requests (combinational read, synchronous write) while it runs. When `sort_done` rises, it streams the sorted words back out with a valid/ready handshake. It sits between the host datapath and the sorter and is the responder end of the sorter's memory port.

---
 rtl/sort_pkg.sv | 15 +
 rtl/sort_ram.sv | 25 ++
 rtl/sort_mem_host.sv | 138 +++++++++++++
 tb/tb_sort_mem_host.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and widths for the bubble sorter and its host-side memory owner.
//   ctrl_state_t : host controller states
//   DATA_W       : word width of the sort memory
//   LEN_W        : width of the sort_length field handed to the sorter
package sort_pkg;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    LOAD,
    SORT_GO,
    SORT_WAIT,
    DRAIN
  } ctrl_state_t;
endpackage

// File: rtl/sort_ram.sv
// Single-port word RAM: asynchronous read, synchronous write, no reset.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write index
//   wdata : write data
//   rdata : combinational mem[addr]
module sort_ram
  import sort_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/sort_mem_host.sv
// Host-side owner of the sorter's word memory. Loads a host word stream,
// kicks the sorter, serves its memory port while it runs, then drains the
// sorted words back to the host.
//   clk, reset                          : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last   : host load stream
//   out_valid/out_ready/out_data/out_last : sorted drain stream
//   sort_go, sort_length, sort_done     : sorter control
//   srt_addr, srt_wdata, srt_we, srt_rdata : sorter memory port
//   busy  : controller is not in LOAD
//   trunc : last load filled the RAM without seeing in_last
module sort_mem_host
  import sort_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              sort_go,
  output logic [LEN_W-1:0]  sort_length,
  input  logic              sort_done,
  input  logic [31:0]       srt_addr,
  input  logic [DATA_W-1:0] srt_wdata,
  input  logic              srt_we,
  output logic [DATA_W-1:0] srt_rdata,
  output logic              busy,
  output logic              trunc
);
  ctrl_state_t       state, state_nxt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [LEN_W-1:0]  len_q;
  logic              trunc_q, done_q;

  logic              accept, at_top, load_end, last_rd, done_rise, drain_hs;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Upper sorter address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^srt_addr;

  assign accept    = (state == LOAD) && in_valid;
  assign at_top    = (wr_ptr == AW'(DEPTH - 1));
  assign load_end  = accept && (in_last || at_top);
  assign last_rd   = ({1'b0, rd_ptr} == count - (AW+1)'(1));
  assign done_rise = sort_done && !done_q;
  assign drain_hs  = (state == DRAIN) && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      // A single word is already sorted; the sorter would read past it.
      LOAD:      if (load_end) state_nxt = (wr_ptr == '0) ? DRAIN : SORT_GO;
      SORT_GO:   state_nxt = SORT_WAIT;
      // Only a fresh rising edge counts; a level left high by the previous
      // run must not end this one.
      SORT_WAIT: if (done_rise) state_nxt = DRAIN;
      DRAIN:     if (drain_hs && last_rd) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

  // RAM port mux: host owns it in LOAD/DRAIN, sorter in SORT_WAIT.
  always_comb begin
    ram_addr  = srt_addr[AW-1:0];
    ram_wdata = srt_wdata;
    ram_we    = 1'b0;
    case (state)
      LOAD: begin
        ram_addr  = wr_ptr;
        ram_wdata = in_data;
        ram_we    = in_valid;
      end
      SORT_WAIT: ram_we = srt_we;
      DRAIN:     ram_addr = rd_ptr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOAD;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= sort_done;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (at_top && !in_last) trunc_q <= 1'b1;
        else if (wr_ptr == '0)  trunc_q <= 1'b0;
        if (load_end) begin
          count <= {1'b0, wr_ptr} + (AW+1)'(1);
          len_q <= LEN_W'(wr_ptr);
        end
      end
      if (drain_hs) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (last_rd) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end
      end
    end
  end

  sort_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign in_ready    = (state == LOAD);
  assign out_valid   = (state == DRAIN);
  assign out_last    = (state == DRAIN) && last_rd;
  assign out_data    = ram_rdata;
  assign srt_rdata   = ram_rdata;
  assign sort_go     = (state == SORT_GO);
  assign sort_length = len_q;
  assign busy        = (state != LOAD);
  assign trunc       = trunc_q;
endmodule

// File: tb/tb_sort_mem_host.sv
// Self-checking bench for sort_mem_host (DEPTH=8) with a behavioural sorter.
module tb_sort_mem_host;
  localparam int DEPTH = 8;

  logic        clk, reset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        sort_go, sort_done, srt_we, busy, trunc;
  logic [15:0] sort_length;
  logic [31:0] srt_addr, srt_wdata, srt_rdata;

  sort_mem_host #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sort_go(sort_go), .sort_length(sort_length), .sort_done(sort_done),
    .srt_addr(srt_addr), .srt_wdata(srt_wdata), .srt_we(srt_we), .srt_rdata(srt_rdata),
    .busy(busy), .trunc(trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] wq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: the drained stream is the accepted words in ascending order.
  function automatic void build_exp();
    logic [31:0] k;
    int j;
    exp_q = acc_q;
    for (int i = 1; i < exp_q.size(); i++) begin
      k = exp_q[i];
      j = i - 1;
      while (j >= 0 && exp_q[j] > k) begin
        exp_q[j+1] = exp_q[j];
        j--;
      end
      exp_q[j+1] = k;
    end
  endfunction

  // Offers words; stops when the host refuses (truncation) or all are sent.
  task automatic load(input logic [31:0] w[$], input bit use_last, input int gap_pct);
    int i;
    int guard;
    i = 0;
    guard = 0;
    acc_q.delete();
    while (i < w.size() && guard < 200) begin
      guard++;
      if (!in_ready) break;
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        cyc();
        continue;
      end
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = use_last && (i == w.size() - 1);
      acc_q.push_back(w[i]);
      i++;
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    build_exp();
  endtask

  // Behavioural sorter: called in the SORT_GO cycle.
  task automatic run_sorter(input int stale);
    check("sort_go", sort_go, 1);
    check("sort_len", sort_length, acc_q.size() - 1);
    check("busy_go", busy, 1);
    cyc();
    check("go_once", sort_go, 0);
    for (int k = 0; k < stale; k++) begin
      check("stale_hold", out_valid, 0);
      cyc();
    end
    sort_done = 1'b0;
    for (int i = 0; i < acc_q.size(); i++) begin
      srt_addr = i;
      #1;
      check("srt_rd", srt_rdata, acc_q[i]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      srt_addr  = i;
      srt_wdata = exp_q[i];
      srt_we    = 1'b1;
      cyc();
      check("wait_nodrain", out_valid, 0);
    end
    srt_we = 1'b0;
    srt_addr = 0;
    #1;
    check("srt_wr_vis", srt_rdata, exp_q[0]);
    sort_done = 1'b1;
    cyc();
    check("done_to_valid", out_valid, 1);
  endtask

  // mode 0: always ready, 1: 1,0,0 pattern, 2: random
  task automatic drain(input int mode);
    int idx;
    int guard;
    bit rdy, prev_stall;
    logic [31:0] prev_data;
    idx = 0;
    guard = 0;
    prev_stall = 0;
    prev_data = '0;
    while (idx < exp_q.size() && guard < 500) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (guard % 3 == 0);
        default: rdy = ($urandom_range(1) == 1);
      endcase
      guard++;
      out_ready = rdy;
      if (!out_valid) begin
        check("drain_valid", out_valid, 1);
        break;
      end
      if (prev_stall) check("stall_hold", out_data, prev_data);
      if (rdy) begin
        check("drain_data", out_data, exp_q[idx]);
        check("drain_last", out_last, (idx == exp_q.size() - 1));
        idx++;
      end
      prev_stall = !rdy;
      prev_data  = out_data;
      cyc();
    end
    out_ready = 1'b0;
    check("drain_cnt", idx, exp_q.size());
    check("back_load", in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; in_last = 0; in_data = '0;
    out_ready = 0; sort_done = 0; srt_we = 0; srt_addr = '0; srt_wdata = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_go", sort_go, 0);
    check("rst_trunc", trunc, 0);
    check("rst_len", sort_length, 0);
    reset = 1'b1;
    cyc();
    check("rst_inready", in_ready, 1);

    // Basic four-word sort
    wq = '{32'd5, 32'd3, 32'd9, 32'd1};
    load(wq, 1, 0);
    run_sorter(0);
    drain(0);

    // Single word skips the sorter
    wq = '{32'd42};
    load(wq, 1, 0);
    check("one_nogo", sort_go, 0);
    check("one_valid", out_valid, 1);
    check("one_last", out_last, 1);
    check("one_data", out_data, 42);
    drain(0);

    // Truncation at DEPTH
    wq.delete();
    for (int i = 0; i < 10; i++) wq.push_back($urandom);
    load(wq, 0, 0);
    check("trunc_cnt", acc_q.size(), DEPTH);
    check("trunc_rdy", in_ready, 0);
    check("trunc_set", trunc, 1);
    run_sorter(1);
    drain(1);
    wq = '{32'd10, 32'd7, 32'd8};
    load(wq, 1, 0);
    check("trunc_clr", trunc, 0);
    run_sorter(3);  // sort_done still high from the previous run
    drain(1);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(2, DEPTH);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom_range(0, 99));
      load(wq, 1, 30);
      run_sorter($urandom_range(1, 3));
      drain(2);
    end

    // Reset mid SORT_WAIT
    wq = '{32'd7, 32'd4, 32'd6};
    load(wq, 1, 0);
    cyc();
    cyc();
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovalid", out_valid, 0);
    check("mid_rst_olast", out_last, 0);
    check("mid_rst_go", sort_go, 0);
    check("mid_rst_len", sort_length, 0);
    check("mid_rst_inrdy", in_ready, 1);
    #2;
    reset = 1'b1;
    sort_done = 1'b0;
    cyc();
    srt_we = 1'b1; srt_addr = 1; srt_wdata = 32'hdead_beef;
    wq = '{32'd2, 32'd1};
    load(wq, 1, 0);
    srt_we = 1'b0;
    run_sorter(1);
    drain(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
